// File: rtl/multi_debounce.sv
// multi_debounce: N-channel push-button conditioner.
// Each channel synchronises its raw pin and debounces it with a stability
// counter. It produces a registered level, one-cycle rise/fall pulses, and a
// press pulse. The press pulse fires on rise and can auto-repeat while the
// button is held.
module multi_debounce #(
    parameter int CHANNELS      = 5,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 10,
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_RATE   = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] D_in,
    input  logic                repeat_en,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] press
);

    localparam int CW   = $clog2(STABLE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RPT  = 2'd2
    } rpt_state_t;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        logic [CW-1:0]          cnt_q;
        logic                   lvl_q;
        logic                   rise_q;
        logic                   fall_q;
        logic                   press_q;
        logic                   accept;
        logic                   rise_d;
        logic                   fall_d;
        logic                   press_d;
        rpt_state_t             st_q;
        rpt_state_t             st_d;
        logic [RW-1:0]          rcnt_q;
        logic [RW-1:0]          rcnt_d;

        assign s      = sync_q[SYNC_STAGES-1];
        // A change is accepted on the STABLE_CYCLES-th consecutive differing sample.
        assign accept = (s != lvl_q) && (cnt_q == CNT_LAST);
        assign rise_d = accept & s;
        assign fall_d = accept & ~s;

        // Synchronise the asynchronous pin through a shift chain.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], D_in[i]};
            end
        end

        // Stability counter. Any sample equal to the level restarts the count.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q  <= '0;
                lvl_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= rise_d;
                fall_q <= fall_d;
                if ((s == lvl_q) || accept) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                if (accept) begin
                    lvl_q <= s;
                end
            end
        end

        // Repeat FSM state, repeat counter and registered press.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                st_q    <= IDLE;
                rcnt_q  <= '0;
                press_q <= 1'b0;
            end else begin
                st_q    <= st_d;
                rcnt_q  <= rcnt_d;
                press_q <= press_d;
            end
        end

        // Repeat FSM next state. A fall overrides everything, so no press occurs on a fall.
        always_comb begin
            st_d    = st_q;
            rcnt_d  = rcnt_q;
            press_d = 1'b0;
            if (fall_d) begin
                st_d   = IDLE;
                rcnt_d = '0;
            end else begin
                case (st_q)
                    IDLE: begin
                        if (rise_d) begin
                            st_d    = HOLD;
                            rcnt_d  = '0;
                            press_d = 1'b1;
                        end
                    end
                    HOLD: begin
                        if (!repeat_en) begin
                            rcnt_d = '0;
                        end else if (rcnt_q == DELAY_LAST) begin
                            st_d    = RPT;
                            rcnt_d  = '0;
                            press_d = 1'b1;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                    RPT: begin
                        if (!repeat_en) begin
                            st_d   = HOLD;
                            rcnt_d = '0;
                        end else if (rcnt_q == RATE_LAST) begin
                            rcnt_d  = '0;
                            press_d = 1'b1;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                    default: begin
                        st_d   = IDLE;
                        rcnt_d = '0;
                    end
                endcase
            end
        end

        assign level[i] = lvl_q;
        assign rise[i]  = rise_q;
        assign fall[i]  = fall_q;
        assign press[i] = press_q;
    end

endmodule
